// File: rtl/exe_stage.sv
// exe_stage: execute stage of the five-stage LoongArch-subset pipeline.
// Holds one decoded bundle, runs the ALU on it, issues the data-SRAM request
// on the cycle the bundle advances, and feeds forwarding / load-use hazard
// information back to decode. One register slice toward MEM.

// exe_alu: one-hot selected 32-bit ALU. Unselected ops are masked out, so an
// all-zero op code produces a zero result.
module exe_alu (
  input  logic [11:0] i_op,
  input  logic [31:0] i_src1,
  input  logic [31:0] i_src2,
  output logic [31:0] o_result
);
  logic [31:0] w_add;
  logic [31:0] w_sub;
  logic [31:0] w_slt;
  logic [31:0] w_sltu;
  logic [31:0] w_and;
  logic [31:0] w_nor;
  logic [31:0] w_or;
  logic [31:0] w_xor;
  logic [31:0] w_sll;
  logic [31:0] w_srl;
  logic [31:0] w_sra;
  logic [31:0] w_lui;
  logic [4:0]  w_sa;

  assign w_sa   = i_src2[4:0];
  assign w_add  = i_src1 + i_src2;
  assign w_sub  = i_src1 - i_src2;
  assign w_slt  = {31'b0, $signed(i_src1) < $signed(i_src2)};
  assign w_sltu = {31'b0, i_src1 < i_src2};
  assign w_and  = i_src1 & i_src2;
  assign w_nor  = ~(i_src1 | i_src2);
  assign w_or   = i_src1 | i_src2;
  assign w_xor  = i_src1 ^ i_src2;
  assign w_sll  = i_src1 << w_sa;
  assign w_srl  = i_src1 >> w_sa;
  assign w_sra  = $signed(i_src1) >>> w_sa;
  assign w_lui  = i_src2;

  // AND-OR mux over the one-hot op bits
  always_comb begin
    o_result = ({32{i_op[0]}}  & w_add)
             | ({32{i_op[1]}}  & w_sub)
             | ({32{i_op[2]}}  & w_slt)
             | ({32{i_op[3]}}  & w_sltu)
             | ({32{i_op[4]}}  & w_and)
             | ({32{i_op[5]}}  & w_nor)
             | ({32{i_op[6]}}  & w_or)
             | ({32{i_op[7]}}  & w_xor)
             | ({32{i_op[8]}}  & w_sll)
             | ({32{i_op[9]}}  & w_srl)
             | ({32{i_op[10]}} & w_sra)
             | ({32{i_op[11]}} & w_lui);
  end
endmodule

module exe_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  // decode side
  input  logic        ds_to_es_valid,
  input  logic [31:0] ds_pc,
  input  logic [31:0] ds_alu_src1,
  input  logic [31:0] ds_alu_src2,
  input  logic [11:0] ds_alu_op,
  input  logic        ds_sram_en,
  input  logic [3:0]  ds_sram_we,
  input  logic [31:0] ds_st_data,
  input  logic [3:0]  ds_rf_we,
  input  logic [4:0]  ds_rf_waddr,
  input  logic [4:0]  ds_rf_raddr1,
  input  logic [4:0]  ds_rf_raddr2,
  output logic        es_allow_in,
  output logic [3:0]  es_rf_we,
  output logic [4:0]  es_rf_waddr,
  output logic [31:0] es_rf_wdata,
  output logic        es_load_stall,
  // data SRAM
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  // MEM side
  input  logic        ms_allow_in,
  output logic        ms_valid,
  output logic [31:0] ms_pc,
  output logic [31:0] ms_alu_result,
  output logic        ms_is_load,
  output logic [3:0]  ms_rf_we,
  output logic [4:0]  ms_rf_waddr
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [11:0] alu_op;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] st_data;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
  } es_bundle_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        is_load;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
  } ms_bundle_t;

  logic        r_es_valid;
  es_bundle_t  r_es;
  logic        r_ms_valid;
  ms_bundle_t  r_ms;

  es_bundle_t  w_ds_bundle;
  ms_bundle_t  w_ms_next;
  logic [31:0] w_alu_result;
  logic        w_es_ready_go;
  logic        w_es_to_ms_valid;
  logic        w_es_is_store;
  logic        w_es_mem_access;
  logic        w_waddr_nz;
  logic        w_raddr_hit;

  // Bundle as presented by decode
  assign w_ds_bundle = '{
    pc:       ds_pc,
    src1:     ds_alu_src1,
    src2:     ds_alu_src2,
    alu_op:   ds_alu_op,
    sram_en:  ds_sram_en,
    sram_we:  ds_sram_we,
    st_data:  ds_st_data,
    rf_we:    ds_rf_we,
    rf_waddr: ds_rf_waddr
  };

  // Single-cycle stage: always ready once valid
  assign w_es_ready_go    = 1'b1;
  assign es_allow_in      = !r_es_valid || (ms_allow_in && w_es_ready_go);
  assign w_es_to_ms_valid = r_es_valid && w_es_ready_go;

  // Input register: valid tracks decode on any accept, payload only on a real bundle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_es_valid <= 1'b0;
      r_es       <= '0;
      r_es.pc    <= RESET_PC;
    end else if (es_allow_in) begin
      r_es_valid <= ds_to_es_valid;
      if (ds_to_es_valid) r_es <= w_ds_bundle;
    end
  end

  exe_alu u_alu (
    .i_op     (r_es.alu_op),
    .i_src1   (r_es.src1),
    .i_src2   (r_es.src2),
    .o_result (w_alu_result)
  );

  assign w_es_is_store   = |r_es.sram_we;
  assign w_es_mem_access = r_es.sram_en || w_es_is_store;
  assign w_waddr_nz      = r_es.rf_waddr != 5'd0;
  assign w_raddr_hit     = (r_es.rf_waddr == ds_rf_raddr1) || (r_es.rf_waddr == ds_rf_raddr2);

  // SRAM request only on the advancing cycle: a held store is never written
  // twice and a held load never loses its one-cycle-later read data.
  assign data_sram_en    = r_es_valid && ms_allow_in && w_es_mem_access;
  assign data_sram_we    = data_sram_en ? r_es.sram_we : 4'h0;
  assign data_sram_addr  = w_alu_result;
  assign data_sram_wdata = r_es.st_data;

  // Forwarding: loads have no result yet in EXE, so they never forward
  assign es_rf_we      = (r_es_valid && !r_es.sram_en && w_waddr_nz) ? r_es.rf_we : 4'h0;
  assign es_rf_waddr   = r_es.rf_waddr;
  assign es_rf_wdata   = w_alu_result;
  assign es_load_stall = r_es_valid && r_es.sram_en && w_waddr_nz && w_raddr_hit;

  // Stores write no register, so their writeback enable is dropped here
  assign w_ms_next = '{
    pc:         r_es.pc,
    alu_result: w_alu_result,
    is_load:    r_es.sram_en,
    rf_we:      w_es_is_store ? 4'h0 : r_es.rf_we,
    rf_waddr:   r_es.rf_waddr
  };

  // Output register toward MEM, gated by MEM's allow-in
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ms_valid <= 1'b0;
      r_ms       <= '0;
      r_ms.pc    <= RESET_PC;
    end else if (ms_allow_in) begin
      r_ms_valid <= w_es_to_ms_valid;
      if (w_es_to_ms_valid) r_ms <= w_ms_next;
    end
  end

  assign ms_valid      = r_ms_valid;
  assign ms_pc         = r_ms.pc;
  assign ms_alu_result = r_ms.alu_result;
  assign ms_is_load    = r_ms.is_load;
  assign ms_rf_we      = r_ms.rf_we;
  assign ms_rf_waddr   = r_ms.rf_waddr;

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed scenarios plus a randomized run against a
// transaction-level model of the execute stage.
module tb_exe_stage;
  localparam logic [31:0] RST_PC = 32'h1c000000;
  localparam logic [11:0] OP_ADD = 12'h001;

  logic        clk, reset;
  logic        ds_to_es_valid;
  logic [31:0] ds_pc, ds_alu_src1, ds_alu_src2, ds_st_data;
  logic [11:0] ds_alu_op;
  logic        ds_sram_en;
  logic [3:0]  ds_sram_we, ds_rf_we;
  logic [4:0]  ds_rf_waddr, ds_rf_raddr1, ds_rf_raddr2;
  logic        ms_allow_in, es_allow_in, es_load_stall;
  logic [3:0]  es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic [31:0] es_rf_wdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        ms_valid, ms_is_load;
  logic [31:0] ms_pc, ms_alu_result;
  logic [3:0]  ms_rf_we;
  logic [4:0]  ms_rf_waddr;

  int total = 0;
  int bad   = 0;

  exe_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .ds_to_es_valid(ds_to_es_valid), .ds_pc(ds_pc),
    .ds_alu_src1(ds_alu_src1), .ds_alu_src2(ds_alu_src2), .ds_alu_op(ds_alu_op),
    .ds_sram_en(ds_sram_en), .ds_sram_we(ds_sram_we), .ds_st_data(ds_st_data),
    .ds_rf_we(ds_rf_we), .ds_rf_waddr(ds_rf_waddr),
    .ds_rf_raddr1(ds_rf_raddr1), .ds_rf_raddr2(ds_rf_raddr2),
    .ms_allow_in(ms_allow_in), .es_allow_in(es_allow_in),
    .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_rf_wdata(es_rf_wdata),
    .es_load_stall(es_load_stall),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .ms_valid(ms_valid), .ms_pc(ms_pc), .ms_alu_result(ms_alu_result),
    .ms_is_load(ms_is_load), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] pc, a, b, input logic [11:0] op,
                       input logic ld, input logic [3:0] we, input logic [31:0] st,
                       input logic [3:0] rfwe, input logic [4:0] wa);
    ds_to_es_valid = v; ds_pc = pc; ds_alu_src1 = a; ds_alu_src2 = b; ds_alu_op = op;
    ds_sram_en = ld; ds_sram_we = we; ds_st_data = st; ds_rf_we = rfwe; ds_rf_waddr = wa;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 12'h0, 1'b0, 4'h0, 32'h0, 4'h0, 5'd0);
  endtask

  // one clock: inputs set before, observe at the following falling edge
  task automatic adv();
    @(posedge clk); @(negedge clk);
  endtask

  // Reference ALU from the op table, shifts written without shift operators on signed data
  function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a, b);
    int sh;
    sh = int'(b[4:0]);
    ref_alu = 32'h0;
    for (int i = 0; i < 12; i++) if (op[i]) begin
      case (i)
        0: ref_alu = a + b;
        1: ref_alu = a - b;
        2: ref_alu = ((a[31] && !b[31]) || (a[31] == b[31] && a < b)) ? 32'h1 : 32'h0;
        3: ref_alu = (a < b) ? 32'h1 : 32'h0;
        4: ref_alu = a & b;
        5: ref_alu = ~(a | b);
        6: ref_alu = a | b;
        7: ref_alu = a ^ b;
        8: ref_alu = a << sh;
        9: ref_alu = a >> sh;
        10: ref_alu = a[31] ? ~((~a) >> sh) : (a >> sh);
        default: ref_alu = b;
      endcase
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1; idle(); ms_allow_in = 1'b1; ds_rf_raddr1 = 5'd0; ds_rf_raddr2 = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    adv();
    total++; if (ms_valid !== 1'b0) begin bad++; $display("FAIL rst_ms_valid got=%b exp=0", ms_valid); end
    total++; if (ms_pc !== RST_PC) begin bad++; $display("FAIL rst_ms_pc got=%h exp=%h", ms_pc, RST_PC); end
    total++; if (data_sram_en !== 1'b0) begin bad++; $display("FAIL rst_sram_en got=%b exp=0", data_sram_en); end
    total++; if (es_allow_in !== 1'b1) begin bad++; $display("FAIL rst_allow got=%b exp=1", es_allow_in); end
    total++; if ({es_rf_we, es_load_stall, ms_rf_we, ms_alu_result} !== 41'h0)
      begin bad++; $display("FAIL rst_misc got=%h exp=0", {es_rf_we, es_load_stall, ms_rf_we, ms_alu_result}); end
  endtask

  task automatic test_alu_sweep();
    logic [31:0] exp [12];
    logic [11:0] opv;
    exp = '{32'hffff_fff4, 32'hffff_ffec, 32'h1, 32'h0, 32'h0, 32'h0000_000b,
            32'hffff_fff4, 32'hffff_fff4, 32'hffff_ff00, 32'h0fff_ffff, 32'hffff_ffff, 32'h4};
    ms_allow_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      opv = 12'h1 << i;
      drive(1'b1, 32'h1c00_0100 + 32'(i*4), 32'hffff_fff0, 32'h4, opv, 1'b0, 4'h0, 32'h0, 4'hf, 5'd3);
      adv();
      total++; if (es_rf_wdata !== exp[i]) begin bad++; $display("FAIL alu_op%0d got=%h exp=%h", i, es_rf_wdata, exp[i]); end
      if (i > 0) begin
        total++; if (ms_alu_result !== exp[i-1]) begin bad++; $display("FAIL alu_ms%0d got=%h exp=%h", i-1, ms_alu_result, exp[i-1]); end
      end
    end
    drive(1'b1, 32'h1c00_0200, 32'hffff_fff0, 32'h4, 12'h0, 1'b0, 4'h0, 32'h0, 4'hf, 5'd3);
    adv();
    total++; if (ms_alu_result !== exp[11]) begin bad++; $display("FAIL alu_ms11 got=%h exp=%h", ms_alu_result, exp[11]); end
    total++; if (es_rf_wdata !== 32'h0) begin bad++; $display("FAIL alu_zero_op got=%h exp=0", es_rf_wdata); end
    idle(); adv();
  endtask

  task automatic test_store_stall();
    idle(); ms_allow_in = 1'b1; adv(); adv();
    ms_allow_in = 1'b0;
    drive(1'b1, 32'h1c00_0300, 32'h100, 32'h8, OP_ADD, 1'b0, 4'hf, 32'hdead_beef, 4'h0, 5'd0);
    adv(); idle();
    for (int k = 0; k < 3; k++) begin
      total++; if (data_sram_en !== 1'b0 || es_allow_in !== 1'b0)
        begin bad++; $display("FAIL st_stall%0d got en=%b allow=%b exp en=0 allow=0", k, data_sram_en, es_allow_in); end
      if (k < 2) adv();
    end
    ms_allow_in = 1'b1; #1;
    total++; if ({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata} !== {1'b1, 4'hf, 32'h108, 32'hdead_beef})
      begin bad++; $display("FAIL st_issue got en=%b we=%h addr=%h wd=%h exp 1 f 108 deadbeef",
                            data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata); end
    adv();
    total++; if (data_sram_en !== 1'b0) begin bad++; $display("FAIL st_once got=%b exp=0", data_sram_en); end
    total++; if ({ms_valid, ms_rf_we, ms_alu_result, ms_pc} !== {1'b1, 4'h0, 32'h108, 32'h1c00_0300})
      begin bad++; $display("FAIL st_ms got v=%b we=%h res=%h pc=%h exp 1 0 108 1c000300", ms_valid, ms_rf_we, ms_alu_result, ms_pc); end
  endtask

  task automatic test_load_use();
    ms_allow_in = 1'b0; ds_rf_raddr1 = 5'd0; ds_rf_raddr2 = 5'd5;
    drive(1'b1, 32'h1c00_0400, 32'h200, 32'h0, OP_ADD, 1'b1, 4'h0, 32'h0, 4'hf, 5'd5);
    adv(); idle();
    total++; if (es_load_stall !== 1'b1) begin bad++; $display("FAIL lu_stall2 got=%b exp=1", es_load_stall); end
    total++; if (es_rf_we !== 4'h0) begin bad++; $display("FAIL lu_nofwd got=%h exp=0", es_rf_we); end
    ds_rf_raddr1 = 5'd5; ds_rf_raddr2 = 5'd9; #1;
    total++; if (es_load_stall !== 1'b1) begin bad++; $display("FAIL lu_stall1 got=%b exp=1", es_load_stall); end
    ds_rf_raddr1 = 5'd6; #1;
    total++; if (es_load_stall !== 1'b0) begin bad++; $display("FAIL lu_nohit got=%b exp=0", es_load_stall); end
    ms_allow_in = 1'b1; #1;
    total++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'h0)
      begin bad++; $display("FAIL lu_req got en=%b we=%h exp 1 0", data_sram_en, data_sram_we); end
    adv();
    total++; if (ms_is_load !== 1'b1 || ms_rf_we !== 4'hf)
      begin bad++; $display("FAIL lu_ms got ld=%b we=%h exp 1 f", ms_is_load, ms_rf_we); end
    ms_allow_in = 1'b0; ds_rf_raddr1 = 5'd0; ds_rf_raddr2 = 5'd0;
    drive(1'b1, 32'h1c00_0404, 32'h200, 32'h0, OP_ADD, 1'b1, 4'h0, 32'h0, 4'hf, 5'd0);
    adv(); idle();
    total++; if (es_load_stall !== 1'b0) begin bad++; $display("FAIL lu_r0 got=%b exp=0", es_load_stall); end
    ms_allow_in = 1'b1; adv(); adv();
  endtask

  task automatic test_forward();
    ms_allow_in = 1'b1;
    drive(1'b1, 32'h1c00_0500, 32'h40, 32'h2, OP_ADD, 1'b0, 4'h0, 32'h0, 4'hf, 5'd7);
    adv(); idle();
    total++; if ({es_rf_we, es_rf_waddr, es_rf_wdata} !== {4'hf, 5'd7, 32'h42})
      begin bad++; $display("FAIL fwd_es got we=%h wa=%0d wd=%h exp f 7 42", es_rf_we, es_rf_waddr, es_rf_wdata); end
    adv();
    total++; if ({ms_valid, ms_rf_waddr, ms_alu_result, ms_is_load} !== {1'b1, 5'd7, 32'h42, 1'b0})
      begin bad++; $display("FAIL fwd_ms got v=%b wa=%0d res=%h ld=%b exp 1 7 42 0", ms_valid, ms_rf_waddr, ms_alu_result, ms_is_load); end
    drive(1'b1, 32'h1c00_0504, 32'h40, 32'h2, OP_ADD, 1'b0, 4'h0, 32'h0, 4'hf, 5'd0);
    adv(); idle();
    total++; if (es_rf_we !== 4'h0) begin bad++; $display("FAIL fwd_r0 got=%h exp=0", es_rf_we); end
    adv();
  endtask

  task automatic test_back_to_back();
    logic exp_v [4];
    exp_v = '{1'b1, 1'b0, 1'b1, 1'b0};
    ms_allow_in = 1'b1;
    drive(1'b1, 32'h1c00_0600, 32'h1, 32'h1, OP_ADD, 1'b0, 4'h0, 32'h0, 4'hf, 5'd1);
    adv(); idle();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) drive(1'b1, 32'h1c00_0608, 32'h2, 32'h2, OP_ADD, 1'b0, 4'h0, 32'h0, 4'hf, 5'd2);
      else idle();
      total++; if (es_allow_in !== 1'b1) begin bad++; $display("FAIL b2b_allow%0d got=%b exp=1", k, es_allow_in); end
      adv();
      total++; if (ms_valid !== exp_v[k]) begin bad++; $display("FAIL b2b_ms%0d got=%b exp=%b", k, ms_valid, exp_v[k]); end
    end
    drive(1'b1, 32'h1c00_0700, 32'h300, 32'h0, OP_ADD, 1'b0, 4'hf, 32'h1234, 4'h0, 5'd0);
    adv(); adv();
    total++; if (data_sram_en !== 1'b1 || ms_valid !== 1'b1)
      begin bad++; $display("FAIL mid_pre got en=%b v=%b exp 1 1", data_sram_en, ms_valid); end
    reset = 1'b1; #1;
    total++; if ({ms_valid, data_sram_en, data_sram_we, es_allow_in, ms_pc} !== {1'b0, 1'b0, 4'h0, 1'b1, RST_PC})
      begin bad++; $display("FAIL mid_reset got v=%b en=%b we=%h allow=%b pc=%h", ms_valid, data_sram_en, data_sram_we, es_allow_in, ms_pc); end
    idle(); adv(); reset = 1'b0; adv();
  endtask

  task automatic test_random();
    // model state: one slot in EXE, one in MEM
    logic        e_v, m_v, m_ld;
    logic [31:0] e_pc, e_a, e_b, e_st, m_pc, m_res;
    logic [11:0] e_op;
    logic        e_ld;
    logic [3:0]  e_we, e_rfwe, m_we;
    logic [4:0]  e_wa, m_wa;
    logic [31:0] res;
    logic        x_en, x_stall;
    logic [3:0]  x_fwe;
    logic [3:0]  st_we [4];
    int kind;
    st_we = '{4'hf, 4'h3, 4'h1, 4'hc};
    reset = 1'b1; idle(); ms_allow_in = 1'b1; adv(); reset = 1'b0;
    e_v = 0; m_v = 0; m_ld = 0; e_pc = RST_PC; m_pc = RST_PC; e_a = 0; e_b = 0; e_st = 0;
    m_res = 0; e_op = 0; e_ld = 0; e_we = 0; e_rfwe = 0; m_we = 0; e_wa = 0; m_wa = 0;
    for (int c = 0; c < 400; c++) begin
      kind = int'($urandom_range(0, 3));
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
            ($urandom_range(0, 15) == 0) ? 12'h0 : (12'h1 << $urandom_range(0, 11)),
            kind == 2, (kind == 3) ? st_we[$urandom_range(0, 3)] : 4'h0, $urandom,
            (kind == 3) ? 4'h0 : 4'hf, 5'($urandom_range(0, 7)));
      ms_allow_in  = $urandom_range(0, 9) < 7;
      ds_rf_raddr1 = 5'($urandom_range(0, 7));
      ds_rf_raddr2 = 5'($urandom_range(0, 7));
      #1;
      res     = ref_alu(e_op, e_a, e_b);
      x_en    = e_v && ms_allow_in && (e_ld || e_we != 4'h0);
      x_fwe   = (e_v && !e_ld && e_wa != 0) ? e_rfwe : 4'h0;
      x_stall = e_v && e_ld && e_wa != 0 && (e_wa == ds_rf_raddr1 || e_wa == ds_rf_raddr2);
      total++; if (es_allow_in !== (!e_v || ms_allow_in))
        begin bad++; $display("FAIL rnd_allow c=%0d got=%b exp=%b", c, es_allow_in, !e_v || ms_allow_in); end
      total++; if ({es_rf_we, es_rf_waddr, es_rf_wdata, es_load_stall} !== {x_fwe, e_wa, res, x_stall})
        begin bad++; $display("FAIL rnd_fwd c=%0d got=%h/%0d/%h/%b exp=%h/%0d/%h/%b", c,
                              es_rf_we, es_rf_waddr, es_rf_wdata, es_load_stall, x_fwe, e_wa, res, x_stall); end
      total++; if ({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata} !== {x_en, x_en ? e_we : 4'h0, res, e_st})
        begin bad++; $display("FAIL rnd_sram c=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", c, data_sram_en, data_sram_we,
                              data_sram_addr, data_sram_wdata, x_en, x_en ? e_we : 4'h0, res, e_st); end
      total++; if ({ms_valid, ms_pc, ms_alu_result, ms_is_load, ms_rf_we, ms_rf_waddr} !== {m_v, m_pc, m_res, m_ld, m_we, m_wa})
        begin bad++; $display("FAIL rnd_ms c=%0d got=%b/%h/%h/%b/%h/%0d exp=%b/%h/%h/%b/%h/%0d", c, ms_valid, ms_pc,
                              ms_alu_result, ms_is_load, ms_rf_we, ms_rf_waddr, m_v, m_pc, m_res, m_ld, m_we, m_wa); end
      // advance the model across the coming edge
      if (ms_allow_in) begin
        m_v = e_v;
        if (e_v) begin
          m_pc = e_pc; m_res = res; m_ld = e_ld; m_wa = e_wa;
          m_we = (e_we != 4'h0) ? 4'h0 : e_rfwe;
        end
      end
      if (!e_v || ms_allow_in) begin
        e_v = ds_to_es_valid;
        if (ds_to_es_valid) begin
          e_pc = ds_pc; e_a = ds_alu_src1; e_b = ds_alu_src2; e_op = ds_alu_op; e_ld = ds_sram_en;
          e_we = ds_sram_we; e_st = ds_st_data; e_rfwe = ds_rf_we; e_wa = ds_rf_waddr;
        end
      end
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_alu_sweep();
    test_store_stall();
    test_load_use();
    test_forward();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
